// File: rtl/rv32_pkg.sv
// Shared RV32 fetch-side definitions: base opcodes, the canonical NOP word,
// fetch FSM state encoding and a word-alignment helper.
package rv32_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD,
        HALT
    } fetch_state_t;

    // Clear the byte-offset bits of an address
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_pc_gen.sv
// Fetch PC register: sequential +4 advance and redirect target mux.
// Redirect targets are always forced onto a word boundary here; the top
// decides whether a misaligned target is an error.
module fetch_pc_gen #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        advance,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] fetch_pc
);
    import rv32_pkg::*;

    // Redirect wins over the sequential advance; the increment wraps mod 2^32
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
        end else if (redirect) begin
            fetch_pc <= word_align(redirect_pc);
        end else if (advance) begin
            fetch_pc <= fetch_pc + 32'd4;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues one req/gnt/rvalid read at a
// time, holds the fetched word for the decoder (valid/ready) and handles
// branch/jump redirects by discarding any in-flight fetch.
// Optional build macro FETCH_MISALIGN_CHK_EN: a redirect to a non-word-aligned
// target raises sticky misalign_err and halts fetching until reset. Without
// it the low target bits are silently dropped and misalign_err stays 0.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [6:0]  opcode,
    output logic [31:0] instr_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        bus_err,
    output logic        misalign_err
);
    import rv32_pkg::*;

    // Last wait_cnt value tolerated before declaring a bus timeout
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES) - 32'd1;
    localparam bit          TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);

    fetch_state_t state;
    logic         discard;
    logic [31:0]  wait_cnt;
    logic [31:0]  fetch_pc;
    logic         redirect_act;
    logic         misalign_hit;
    logic         advance;

    // A halted unit ignores redirects entirely
    assign redirect_act = redirect_valid && (state != HALT);

`ifdef FETCH_MISALIGN_CHK_EN
    assign misalign_hit = redirect_act && (redirect_pc[1:0] != 2'b00);
`else
    assign misalign_hit = 1'b0;
`endif

    // PC only steps forward when a non-discarded word is captured
    assign advance   = (state == WAIT) && imem_rvalid && !discard && !redirect_act;
    assign imem_addr = fetch_pc;
    assign opcode    = instr[6:0];

    fetch_pc_gen #(
        .RESET_PC (RESET_PC)
    ) u_pc_gen (
        .clk         (clk),
        .rst_n       (rst_n),
        .advance     (advance),
        .redirect    (redirect_act),
        .redirect_pc (redirect_pc),
        .fetch_pc    (fetch_pc)
    );

    // Fetch FSM with registered bus request, hold buffer and sticky errors
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            imem_req     <= 1'b0;
            instr_valid  <= 1'b0;
            instr        <= NOP_INSTR;
            instr_pc     <= RESET_PC;
            discard      <= 1'b0;
            wait_cnt     <= '0;
            bus_err      <= 1'b0;
            misalign_err <= 1'b0;
        end else if (misalign_hit) begin
            misalign_err <= 1'b1;
            state        <= HALT;
            imem_req     <= 1'b0;
            instr_valid  <= 1'b0;
            discard      <= 1'b0;
        end else if (redirect_act) begin
            // Any held word is dropped; a handshake in this same cycle has
            // already completed, so the branch word counts as consumed.
            instr_valid <= 1'b0;
            if (state == WAIT && !imem_rvalid) begin
                // Response still owed by memory: swallow it when it arrives
                discard  <= 1'b1;
                state    <= WAIT;
                imem_req <= 1'b0;
                wait_cnt <= wait_cnt + 32'd1;
            end else if (state == REQ && imem_gnt) begin
                discard  <= 1'b1;
                state    <= WAIT;
                imem_req <= 1'b0;
                wait_cnt <= '0;
            end else begin
                discard  <= 1'b0;
                state    <= REQ;
                imem_req <= 1'b1;
            end
        end else begin
            case (state)
                IDLE: begin
                    state    <= REQ;
                    imem_req <= 1'b1;
                end
                REQ: begin
                    if (imem_gnt) begin
                        state    <= WAIT;
                        imem_req <= 1'b0;
                        wait_cnt <= '0;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        if (discard) begin
                            discard  <= 1'b0;
                            state    <= REQ;
                            imem_req <= 1'b1;
                        end else begin
                            instr       <= imem_rdata;
                            instr_pc    <= fetch_pc;
                            instr_valid <= 1'b1;
                            state       <= HOLD;
                        end
                    end else if (TIMEOUT_EN && (wait_cnt >= TIMEOUT_LAST)) begin
                        bus_err <= 1'b1;
                        state   <= HALT;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end
                HOLD: begin
                    if (instr_ready) begin
                        instr_valid <= 1'b0;
                        state       <= REQ;
                        imem_req    <= 1'b1;
                    end
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state    <= HALT;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: a memory model checks request
// addresses against an expected-address queue, and a monitor checks every
// decode handshake against an expected-instruction queue.
module tb_instr_fetch_unit;

    typedef struct packed {
        logic [31:0] word;
        logic [31:0] pc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [31:0] instr_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        bus_err;
    logic        misalign_err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    exp_t        exp_q[$];
    logic [31:0] exp_addr[$];
    int          hs_q[$];

    int          grants_left = 0;
    int          mem_lat     = 1;
    bit          mem_stall   = 1'b0;
    int          pend_cnt    = 0;
    logic [31:0] pend_addr   = '0;

    instr_fetch_unit #(
        .RESET_PC       (32'h0000_0000),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .opcode         (opcode),
        .instr_pc       (instr_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .bus_err        (bus_err),
        .misalign_err   (misalign_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory contents: address shifted up, low 7 bits an opcode picked by addr[3:2]
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [6:0] opc;
        case (a[3:2])
            2'd0:    opc = 7'h33;
            2'd1:    opc = 7'h13;
            2'd2:    opc = 7'h03;
            default: opc = 7'h63;
        endcase
        return (a << 5) | {25'd0, opc};
    endfunction

    // Memory model: immediate grant, rvalid mem_lat cycles later
    initial begin
        logic [31:0] ea;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        forever begin
            @(negedge clk);
            imem_gnt    = 1'b0;
            imem_rvalid = 1'b0;
            if (!rst_n) begin
                pend_cnt = 0;
            end else begin
                if (pend_cnt > 0) begin
                    pend_cnt--;
                    if (pend_cnt == 0) begin
                        imem_rvalid = 1'b1;
                        imem_rdata  = mem_word(pend_addr);
                    end
                end
                if (imem_req && grants_left > 0) begin
                    imem_gnt = 1'b1;
                    grants_left--;
                    pend_addr = imem_addr;
                    pend_cnt  = mem_stall ? 0 : mem_lat;
                    checks++;
                    if (exp_addr.size() == 0) begin
                        errors++;
                        $display("FAIL req_addr unexpected request got=%h", imem_addr);
                    end else begin
                        ea = exp_addr.pop_front();
                        if (imem_addr !== ea) begin
                            errors++;
                            $display("FAIL req_addr got=%h exp=%h", imem_addr, ea);
                        end
                    end
                end
            end
        end
    end

    // Decode-side monitor: every handshake must match the next expected word
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && instr_valid && instr_ready) begin
                checks++;
                hs_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL handshake unexpected instr=%h pc=%h", instr, instr_pc);
                end else begin
                    e = exp_q.pop_front();
                    if (instr !== e.word || instr_pc !== e.pc || opcode !== e.word[6:0]) begin
                        errors++;
                        $display("FAIL handshake got instr=%h pc=%h op=%h exp instr=%h pc=%h",
                                 instr, instr_pc, opcode, e.word, e.pc);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        grants_left    = 0;
        mem_stall      = 1'b0;
        mem_lat        = 1;
        tick(2);
        exp_q.delete();
        exp_addr.delete();
        hs_q.delete();
    endtask

    task automatic release_reset();
        rst_n = 1'b1;
    endtask

    task automatic wait_valid(input string nm);
        int n = 0;
        while (!instr_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!instr_valid) begin
            errors++;
            $display("FAIL %s timeout waiting instr_valid got=0 exp=1", nm);
        end
    endtask

    task automatic chk_drained(input string nm);
        checks++;
        if (exp_q.size() != 0 || exp_addr.size() != 0) begin
            errors++;
            $display("FAIL %s_drained instr_left=%0d addr_left=%0d exp=0", nm, exp_q.size(), exp_addr.size());
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        instr_ready    = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;

        // Reset state
        tick(3);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_instr", instr, 32'h0000_0013);
        chk("rst_opcode", {25'd0, opcode}, 32'h13);
        chk("rst_pc", instr_pc, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_bus_err", {31'd0, bus_err}, 32'd0);
        chk("rst_misalign", {31'd0, misalign_err}, 32'd0);

        // Sequential fetch, 1-cycle memory, ready held high
        apply_reset();
        instr_ready = 1'b1;
        exp_addr.push_back(32'h0);
        exp_addr.push_back(32'h4);
        exp_addr.push_back(32'h8);
        exp_q.push_back('{word: 32'h0000_0033, pc: 32'h0});
        exp_q.push_back('{word: 32'h0000_0093, pc: 32'h4});
        exp_q.push_back('{word: 32'h0000_0103, pc: 32'h8});
        grants_left = 3;
        release_reset();
        tick(14);
        chk("seq_hs_count", hs_q.size(), 32'd3);
        if (hs_q.size() == 3) begin
            chk("seq_spacing_1", hs_q[1] - hs_q[0], 32'd3);
            chk("seq_spacing_2", hs_q[2] - hs_q[1], 32'd3);
        end
        chk_drained("seq");

        // Decoder stalls for 5 cycles: held word stable, no new request
        apply_reset();
        instr_ready = 1'b0;
        exp_addr.push_back(32'h0);
        exp_q.push_back('{word: 32'h0000_0033, pc: 32'h0});
        grants_left = 1;
        release_reset();
        wait_valid("stall");
        for (int i = 0; i < 5; i++) begin
            chk("stall_instr", instr, 32'h0000_0033);
            chk("stall_pc", instr_pc, 32'h0);
            chk("stall_req", {31'd0, imem_req}, 32'd0);
            tick(1);
        end
        instr_ready = 1'b1;
        tick(3);
        chk_drained("stall");

        // Redirect while waiting on a 2-cycle read: stale word must be dropped
        apply_reset();
        instr_ready = 1'b1;
        mem_lat     = 2;
        exp_addr.push_back(32'h0);
        exp_addr.push_back(32'h100);
        exp_q.push_back('{word: 32'h0000_2033, pc: 32'h100});
        grants_left = 2;
        release_reset();
        tick(2);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        tick(1);
        redirect_valid = 1'b0;
        tick(1);
        chk("redir_wait_addr", imem_addr, 32'h100);
        chk("redir_wait_req", {31'd0, imem_req}, 32'd1);
        tick(8);
        chk_drained("redir_wait");

        // Redirect in the same cycle as the decode handshake
        apply_reset();
        instr_ready = 1'b0;
        exp_addr.push_back(32'h0);
        exp_addr.push_back(32'h40);
        exp_q.push_back('{word: 32'h0000_0033, pc: 32'h0});
        exp_q.push_back('{word: 32'h0000_0833, pc: 32'h40});
        grants_left = 2;
        release_reset();
        wait_valid("redir_hold");
        instr_ready    = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        tick(1);
        redirect_valid = 1'b0;
        chk("redir_hold_valid", {31'd0, instr_valid}, 32'd0);
        chk("redir_hold_addr", imem_addr, 32'h40);
        tick(6);
        chk_drained("redir_hold");

        // No response within 16 WAIT cycles: sticky bus_err, no more requests
        apply_reset();
        instr_ready = 1'b1;
        mem_stall   = 1'b1;
        exp_addr.push_back(32'h0);
        grants_left = 1;
        release_reset();
        tick(17);
        chk("timeout_before", {31'd0, bus_err}, 32'd0);
        tick(1);
        chk("timeout_bus_err", {31'd0, bus_err}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick(1);
            chk("timeout_req", {31'd0, imem_req}, 32'd0);
        end
        chk("timeout_sticky", {31'd0, bus_err}, 32'd1);
        chk_drained("timeout");
        apply_reset();
        chk("timeout_rst_bus_err", {31'd0, bus_err}, 32'd0);
        chk("timeout_rst_addr", imem_addr, 32'h0);
        chk("timeout_rst_pc", instr_pc, 32'h0);
        exp_addr.push_back(32'h0);
        exp_q.push_back('{word: 32'h0000_0033, pc: 32'h0});
        grants_left = 1;
        release_reset();
        tick(5);
        chk_drained("timeout_recover");

        // Misaligned redirect target 0x102 from HOLD
        apply_reset();
        instr_ready = 1'b0;
        exp_addr.push_back(32'h0);
        grants_left = 1;
`ifndef FETCH_MISALIGN_CHK_EN
        exp_addr.push_back(32'h100);
        exp_q.push_back('{word: 32'h0000_2033, pc: 32'h100});
        grants_left = 2;
`endif
        release_reset();
        wait_valid("misalign");
        redirect_valid = 1'b1;
        redirect_pc    = 32'h102;
        tick(1);
        redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
        chk("misalign_err", {31'd0, misalign_err}, 32'd1);
        chk("misalign_valid", {31'd0, instr_valid}, 32'd0);
        grants_left = 3;
        for (int i = 0; i < 4; i++) begin
            chk("misalign_req", {31'd0, imem_req}, 32'd0);
            tick(1);
        end
        grants_left = 0;
`else
        chk("misalign_err", {31'd0, misalign_err}, 32'd0);
        chk("misalign_addr", imem_addr, 32'h100);
        instr_ready = 1'b1;
        tick(6);
`endif
        chk_drained("misalign");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
